// File: rtl/axis_pattern_src.sv
// ---------------------------------------------------------------------------
// axis_pattern_src
//
// AXI4-Stream video test-pattern source. Emits frames of H_ACTIVE x V_ACTIVE
// pixels in one of four patterns (solid, colour bars, checkerboard, ramp),
// honouring tready backpressure. tuser marks pixel (0,0) and tlast marks the
// last pixel of every line. Optional idle gap between frames.
//
// Ports
//   pixel_clk      : clock for all logic
//   aresetn        : asynchronous reset, active low
//   enable         : run request, only looked at on frame boundaries
//   mode           : 0 solid, 1 colour bars, 2 checker, 3 ramp
//   solid_rgb      : colour for mode 0, packed like tdata
//   m_axis_tdata   : pixel, {R, B, G}, BPC bits each
//   m_axis_tvalid  : pixel valid
//   m_axis_tready  : sink ready
//   m_axis_tuser   : start of frame (pixel (0,0) only)
//   m_axis_tlast   : end of line
//   frame_count    : completed frames, wraps at 16 bits
//   frame_done     : one-cycle pulse after the last pixel of a frame transfers
//   busy           : high while streaming or in the inter-frame gap
// ---------------------------------------------------------------------------
module axis_pattern_src #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int BPC        = 8,
    parameter int CHECK_LOG2 = 5,
    parameter int GAP_CYCLES = 16
) (
    input  logic               pixel_clk,
    input  logic               aresetn,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [3*BPC-1:0]   solid_rgb,
    output logic [3*BPC-1:0]   m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tuser,
    output logic               m_axis_tlast,
    output logic [15:0]        frame_count,
    output logic               frame_done,
    output logic               busy
);

    localparam int DW     = 3 * BPC;
    // Counters are widened so that bit CHECK_LOG2 always exists.
    localparam int XW_MIN = $clog2(H_ACTIVE);
    localparam int YW_MIN = $clog2(V_ACTIVE);
    localparam int XW     = (XW_MIN > CHECK_LOG2) ? XW_MIN : CHECK_LOG2 + 1;
    localparam int YW     = (YW_MIN > CHECK_LOG2) ? YW_MIN : CHECK_LOG2 + 1;
    localparam int GW     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_GAP
    } state_t;

    // First x of bar k+1; all entries are elaboration-time constants.
    function automatic logic [XW-1:0] bar_end(input logic [2:0] k);
        case (k)
            3'd0:    bar_end = XW'(H_ACTIVE * 1 / 8);
            3'd1:    bar_end = XW'(H_ACTIVE * 2 / 8);
            3'd2:    bar_end = XW'(H_ACTIVE * 3 / 8);
            3'd3:    bar_end = XW'(H_ACTIVE * 4 / 8);
            3'd4:    bar_end = XW'(H_ACTIVE * 5 / 8);
            3'd5:    bar_end = XW'(H_ACTIVE * 6 / 8);
            3'd6:    bar_end = XW'(H_ACTIVE * 7 / 8);
            default: bar_end = X_LAST;
        endcase
    endfunction

    // Full-scale colour from per-component on/off flags, packed {R, B, G}.
    function automatic logic [DW-1:0] rgb_flags(input logic r, input logic g, input logic b);
        rgb_flags = {{BPC{r}}, {BPC{b}}, {BPC{g}}};
    endfunction

    function automatic logic [DW-1:0] pattern(
        input logic [1:0]    m,
        input logic [DW-1:0] rgb,
        input logic          chk,
        input logic [BPC-1:0] lvl,
        input logic [2:0]    bar
    );
        case (m)
            2'd0: pattern = rgb;
            2'd1: begin
                case (bar)
                    3'd0:    pattern = rgb_flags(1'b1, 1'b1, 1'b1); // white
                    3'd1:    pattern = rgb_flags(1'b1, 1'b1, 1'b0); // yellow
                    3'd2:    pattern = rgb_flags(1'b0, 1'b1, 1'b1); // cyan
                    3'd3:    pattern = rgb_flags(1'b0, 1'b1, 1'b0); // green
                    3'd4:    pattern = rgb_flags(1'b1, 1'b0, 1'b1); // magenta
                    3'd5:    pattern = rgb_flags(1'b1, 1'b0, 1'b0); // red
                    3'd6:    pattern = rgb_flags(1'b0, 1'b0, 1'b1); // blue
                    default: pattern = '0;                          // black
                endcase
            end
            2'd2:    pattern = chk ? '1 : '0;
            default: pattern = {3{lvl}};
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [2:0]      bar_q, bar_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [1:0]      mode_q, mode_d;
    logic [DW-1:0]   rgb_q, rgb_d;
    logic [DW-1:0]   tdata_q, tdata_d;
    logic            tvalid_q, tvalid_d;
    logic            tuser_q, tuser_d;
    logic            tlast_q, tlast_d;
    logic [15:0]     count_q, count_d;
    logic            done_q, done_d;

    logic            xfer;
    logic            last_px;
    logic            start_frame;
    logic [XW-1:0]   nx;
    logic [YW-1:0]   ny;
    logic [2:0]      nbar;

    assign xfer    = tvalid_q & m_axis_tready;
    assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        bar_d       = bar_q;
        gap_d       = gap_q;
        mode_d      = mode_q;
        rgb_d       = rgb_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tuser_d     = tuser_q;
        tlast_d     = tlast_q;
        count_d     = count_q;
        done_d      = 1'b0;
        start_frame = 1'b0;

        // Coordinates of the pixel following the one currently presented.
        nx = (x_q == X_LAST) ? '0 : x_q + 1'b1;
        ny = (x_q == X_LAST) ? y_q + 1'b1 : y_q;
        // Bar index is a counter stepped at constant boundaries, cleared per line.
        if (x_q == X_LAST) begin
            nbar = '0;
        end else if ((bar_q != 3'd7) && (nx == bar_end(bar_q))) begin
            nbar = bar_q + 3'd1;
        end else begin
            nbar = bar_q;
        end

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    start_frame = 1'b1;
                end
            end
            S_STREAM: begin
                if (xfer) begin
                    if (last_px) begin
                        done_d  = 1'b1;
                        count_d = count_q + 16'd1;
                        if (GAP_CYCLES > 0) begin
                            state_d  = S_GAP;
                            gap_d    = '0;
                            tvalid_d = 1'b0;
                            tuser_d  = 1'b0;
                            tlast_d  = 1'b0;
                        end else if (enable) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d  = S_IDLE;
                            tvalid_d = 1'b0;
                            tuser_d  = 1'b0;
                            tlast_d  = 1'b0;
                        end
                    end else begin
                        x_d     = nx;
                        y_d     = ny;
                        bar_d   = nbar;
                        tdata_d = pattern(mode_q, rgb_q, nx[CHECK_LOG2] ^ ny[CHECK_LOG2],
                                          BPC'(nx), nbar);
                        tuser_d = 1'b0;
                        tlast_d = (nx == X_LAST);
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (enable) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Frame start: latch pattern controls and present pixel (0,0) next cycle.
        if (start_frame) begin
            state_d  = S_STREAM;
            mode_d   = mode;
            rgb_d    = solid_rgb;
            x_d      = '0;
            y_d      = '0;
            bar_d    = '0;
            tdata_d  = pattern(mode, solid_rgb, 1'b0, '0, 3'd0);
            tvalid_d = 1'b1;
            tuser_d  = 1'b1;
            tlast_d  = 1'b0;
        end
    end

    always_ff @(posedge pixel_clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            bar_q    <= '0;
            gap_q    <= '0;
            mode_q   <= '0;
            rgb_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            count_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            bar_q    <= bar_d;
            gap_q    <= gap_d;
            mode_q   <= mode_d;
            rgb_q    <= rgb_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            count_q  <= count_d;
            done_q   <= done_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;
    assign frame_count   = count_q;
    assign frame_done    = done_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_axis_pattern_src.sv
module tb_axis_pattern_src;

    logic        pixel_clk = 1'b0;
    logic        aresetn;
    logic        en   [3];
    logic [1:0]  md   [3];
    logic [23:0] rgb  [3];
    logic        rdy  [3];
    logic [23:0] td   [3];
    logic        tv   [3];
    logic        tu   [3];
    logic        tl   [3];
    logic        done [3];
    logic        busy [3];
    logic [15:0] fc   [3];

    int H [3] = '{16, 16, 640};
    int V [3] = '{4, 4, 3};
    int C [3] = '{1, 1, 5};

    int checks = 0;
    int errors = 0;
    logic [25:0] sb [$];   // {tuser, tlast, tdata}

    always #5 pixel_clk = ~pixel_clk;

    // Instance 0: small frame with an inter-frame gap
    axis_pattern_src #(.H_ACTIVE(16), .V_ACTIVE(4), .BPC(8), .CHECK_LOG2(1), .GAP_CYCLES(4)) u_a (
        .pixel_clk(pixel_clk), .aresetn(aresetn), .enable(en[0]), .mode(md[0]),
        .solid_rgb(rgb[0]), .m_axis_tdata(td[0]), .m_axis_tvalid(tv[0]),
        .m_axis_tready(rdy[0]), .m_axis_tuser(tu[0]), .m_axis_tlast(tl[0]),
        .frame_count(fc[0]), .frame_done(done[0]), .busy(busy[0]));

    // Instance 1: small frame, back-to-back frames
    axis_pattern_src #(.H_ACTIVE(16), .V_ACTIVE(4), .BPC(8), .CHECK_LOG2(1), .GAP_CYCLES(0)) u_b (
        .pixel_clk(pixel_clk), .aresetn(aresetn), .enable(en[1]), .mode(md[1]),
        .solid_rgb(rgb[1]), .m_axis_tdata(td[1]), .m_axis_tvalid(tv[1]),
        .m_axis_tready(rdy[1]), .m_axis_tuser(tu[1]), .m_axis_tlast(tl[1]),
        .frame_count(fc[1]), .frame_done(done[1]), .busy(busy[1]));

    // Instance 2: full-width lines, short frame
    axis_pattern_src #(.H_ACTIVE(640), .V_ACTIVE(3), .BPC(8), .CHECK_LOG2(5), .GAP_CYCLES(2)) u_c (
        .pixel_clk(pixel_clk), .aresetn(aresetn), .enable(en[2]), .mode(md[2]),
        .solid_rgb(rgb[2]), .m_axis_tdata(td[2]), .m_axis_tvalid(tv[2]),
        .m_axis_tready(rdy[2]), .m_axis_tuser(tu[2]), .m_axis_tlast(tl[2]),
        .frame_count(fc[2]), .frame_done(done[2]), .busy(busy[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference pixel model, packing {R, B, G}
    function automatic logic [23:0] exp_px(input int m, input logic [23:0] c,
                                          input int x, input int y, input int h, input int cl);
        logic [23:0] bars [8];
        int k;
        bars = '{24'hFFFFFF, 24'hFF00FF, 24'h00FFFF, 24'h0000FF,
                 24'hFFFF00, 24'hFF0000, 24'h00FF00, 24'h000000};
        case (m)
            0: return c;
            1: begin
                k = 0;
                for (int j = 1; j < 8; j++) if (x >= j * h / 8) k = j;
                return bars[k];
            end
            2: return ((((x >> cl) ^ (y >> cl)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            default: return {3{8'(x % 256)}};
        endcase
    endfunction

    task automatic push_frame(input int d, input int m, input logic [23:0] c);
        for (int y = 0; y < V[d]; y++)
            for (int x = 0; x < H[d]; x++)
                sb.push_back({(x == 0 && y == 0), (x == H[d] - 1), exp_px(m, c, x, y, H[d], C[d])});
    endtask

    // Consume nbeats transfers from instance d, comparing against the scoreboard.
    // After drop_at transfers, enable is dropped and mode/colour are changed.
    task automatic drain(input int d, input int nbeats, input bit rnd, input int drop_at,
                         input logic [1:0] new_mode, output int lows, output int ndone);
        int got = 0;
        int cyc = 0;
        logic stalled = 1'b0;
        logic [25:0] held = '0;
        logic [25:0] beat;
        logic [25:0] e;
        lows = 0;
        ndone = 0;
        while (got < nbeats && cyc < nbeats * 4 + 200) begin
            @(negedge pixel_clk);
            cyc++;
            if (done[d]) ndone++;
            if (!tv[d] && got > 0) lows++;
            beat = {tu[d], tl[d], td[d]};
            if (stalled) chk("stall_hold", 32'({tv[d], beat}), 32'({1'b1, held}));
            rdy[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (got == drop_at) begin
                en[d]  = 1'b0;
                md[d]  = new_mode;
                rgb[d] = 24'h0F0F0F;
            end
            if (tv[d] && rdy[d]) begin
                if (sb.size() > 0) e = sb.pop_front();
                else e = '1;
                chk("beat", 32'(beat), 32'(e));
                got++;
                stalled = 1'b0;
            end else begin
                stalled = tv[d];
                held = beat;
            end
        end
        @(negedge pixel_clk);
        if (done[d]) ndone++;
        rdy[d] = 1'b0;
        chk("beat_count", 32'(got), 32'(nbeats));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lows;
        int nd;
        for (int d = 0; d < 3; d++) begin
            en[d] = 1'b0; md[d] = 2'd0; rgb[d] = 24'h0; rdy[d] = 1'b0;
        end
        aresetn = 1'b0;
        en[0] = 1'b1;
        rgb[0] = 24'h123456;
        repeat (3) @(negedge pixel_clk);

        // Reset values with enable already requested
        for (int d = 0; d < 3; d++) begin
            chk("rst_tvalid", 32'(tv[d]), 32'(0));
            chk("rst_tuser", 32'(tu[d]), 32'(0));
            chk("rst_tlast", 32'(tl[d]), 32'(0));
            chk("rst_tdata", 32'(td[d]), 32'(0));
            chk("rst_done", 32'(done[d]), 32'(0));
            chk("rst_busy", 32'(busy[d]), 32'(0));
            chk("rst_count", 32'(fc[d]), 32'(0));
        end
        aresetn = 1'b1;
        @(posedge pixel_clk);
        @(posedge pixel_clk);
        #1;
        chk("start_tvalid", 32'(tv[0]), 32'(1));
        chk("start_tuser", 32'(tu[0]), 32'(1));
        chk("start_tdata", 32'(td[0]), 32'h123456);
        chk("start_busy", 32'(busy[0]), 32'(1));

        // Solid frame, full throughput
        push_frame(0, 0, 24'h123456);
        drain(0, 64, 1'b0, 1, 2'd0, lows, nd);
        chk("solid_lows", 32'(lows), 32'(0));
        chk("solid_done", 32'(nd), 32'(1));
        chk("solid_count", 32'(fc[0]), 32'(1));
        repeat (6) @(negedge pixel_clk);
        chk("solid_idle_busy", 32'(busy[0]), 32'(0));
        chk("solid_idle_tvalid", 32'(tv[0]), 32'(0));

        // Colour bars; mode change mid-frame must be ignored
        md[0] = 2'd1; en[0] = 1'b1;
        push_frame(0, 1, 24'h0);
        drain(0, 64, 1'b0, 1, 2'd2, lows, nd);
        chk("bars_done", 32'(nd), 32'(1));
        chk("bars_count", 32'(fc[0]), 32'(2));
        repeat (6) @(negedge pixel_clk);

        // Checkerboard
        md[0] = 2'd2; en[0] = 1'b1;
        push_frame(0, 2, 24'h0);
        drain(0, 64, 1'b0, 1, 2'd0, lows, nd);
        chk("chk_count", 32'(fc[0]), 32'(3));
        repeat (6) @(negedge pixel_clk);

        // Solid frame under random backpressure
        md[0] = 2'd0; rgb[0] = 24'h123456; en[0] = 1'b1;
        push_frame(0, 0, 24'h123456);
        drain(0, 64, 1'b1, 1, 2'd3, lows, nd);
        chk("bp_lows", 32'(lows), 32'(0));
        chk("bp_done", 32'(nd), 32'(1));
        chk("bp_count", 32'(fc[0]), 32'(4));
        repeat (6) @(negedge pixel_clk);

        // Two frames with a 4-cycle gap
        md[0] = 2'd0; rgb[0] = 24'hABCDEF; en[0] = 1'b1;
        push_frame(0, 0, 24'hABCDEF);
        push_frame(0, 0, 24'hABCDEF);
        drain(0, 128, 1'b0, 65, 2'd0, lows, nd);
        chk("gap_lows", 32'(lows), 32'(4));
        chk("gap_done", 32'(nd), 32'(2));
        chk("gap_count", 32'(fc[0]), 32'(6));
        repeat (6) @(negedge pixel_clk);
        chk("gap_idle_busy", 32'(busy[0]), 32'(0));

        // Two back-to-back ramp frames with no gap
        md[1] = 2'd3; en[1] = 1'b1;
        push_frame(1, 3, 24'h0);
        push_frame(1, 3, 24'h0);
        drain(1, 128, 1'b0, 65, 2'd3, lows, nd);
        chk("b2b_lows", 32'(lows), 32'(0));
        chk("b2b_done", 32'(nd), 32'(2));
        chk("b2b_count", 32'(fc[1]), 32'(2));
        repeat (3) @(negedge pixel_clk);
        chk("b2b_idle_busy", 32'(busy[1]), 32'(0));

        // Enable dropped and mode switched at pixel (5,2): frame finishes solid
        md[2] = 2'd0; rgb[2] = 24'h00FF00; en[2] = 1'b1;
        push_frame(2, 0, 24'h00FF00);
        drain(2, 1920, 1'b0, 2 * 640 + 5, 2'd3, lows, nd);
        chk("drop_done", 32'(nd), 32'(1));
        chk("drop_count", 32'(fc[2]), 32'(1));
        repeat (5) @(negedge pixel_clk);
        chk("drop_idle_busy", 32'(busy[2]), 32'(0));
        chk("drop_idle_tvalid", 32'(tv[2]), 32'(0));

        // Re-enable: ramp frame
        en[2] = 1'b1;
        push_frame(2, 3, 24'h0);
        drain(2, 1920, 1'b0, 1, 2'd3, lows, nd);
        chk("ramp_count", 32'(fc[2]), 32'(2));
        repeat (5) @(negedge pixel_clk);

        // Reset in the middle of a frame
        md[2] = 2'd1; en[2] = 1'b1;
        push_frame(2, 1, 24'h0);
        drain(2, 10, 1'b0, 1, 2'd1, lows, nd);
        sb.delete();
        @(negedge pixel_clk);
        aresetn = 1'b0;
        #1;
        chk("midrst_tvalid", 32'(tv[2]), 32'(0));
        chk("midrst_busy", 32'(busy[2]), 32'(0));
        chk("midrst_count", 32'(fc[2]), 32'(0));
        chk("midrst_tdata", 32'(td[2]), 32'(0));
        chk("midrst_tuser", 32'(tu[2]), 32'(0));
        repeat (3) @(negedge pixel_clk);
        chk("midrst_done", 32'(done[2]), 32'(0));
        aresetn = 1'b1;
        repeat (2) @(negedge pixel_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_pattern_src.md
Name: axis_pattern_src

Overview:
Parametrised AXI4-Stream video source for the display pipeline. It generates complete frames of H_ACTIVE x V_ACTIVE pixels in one of four test patterns (solid, colour bars, checkerboard, ramp), honours tready backpressure, and marks start-of-frame and end-of-line. It replaces the fixed 640x480 RGB444 video_gen path and feeds the AXI4-Stream-to-video-out input of the HDMI block design directly.

Parameters:
H_ACTIVE, 640, active pixels per line (>= 8)
V_ACTIVE, 480, active lines per frame (>= 1)
BPC, 8, bits per colour component; TDATA width = 3*BPC
CHECK_LOG2, 5, checker square size = 2^CHECK_LOG2 pixels (must be < x/y counter width)
GAP_CYCLES, 16, idle cycles with tvalid low between frames (0 allowed)

Ports:
pixel_clk  in  1  single clock for all logic
aresetn  in  1  asynchronous reset, active low
enable  in  1  run request; sampled at frame boundaries
mode  in  2  0 solid, 1 colour bars, 2 checker, 3 ramp
solid_rgb  in  3*BPC  colour for mode 0, packed as tdata
m_axis_tdata  out  3*BPC  pixel: [3*BPC-1:2*BPC]=R, [2*BPC-1:BPC]=B, [BPC-1:0]=G
m_axis_tvalid  out  1  pixel valid
m_axis_tready  in  1  sink ready
m_axis_tuser  out  1  start of frame, high on pixel (0,0) only
m_axis_tlast  out  1  end of line, high on x = H_ACTIVE-1
frame_count  out  16  completed frames, wraps
frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted
busy  out  1  high in STREAM or GAP

Behaviour:
- Reset (aresetn low, async): state IDLE; tvalid, tuser, tlast, frame_done, busy = 0; tdata = 0; frame_count = 0; x = y = 0.
- States: IDLE, STREAM, GAP.
- IDLE -> STREAM on the edge where enable=1. mode and solid_rgb are latched at this edge. tvalid goes high the next cycle with pixel (0,0) and tuser=1.
- Handshake: a beat transfers when tvalid & tready. While tvalid=1 and tready=0, tdata, tuser and tlast hold stable. tvalid never drops mid-frame.
- x/y advance only on a transfer. x wraps at H_ACTIVE-1 and increments y. Outputs are registered; the next pixel is presented the cycle after a transfer, so the sink sees full throughput when tready stays high.
- On transfer of pixel (H_ACTIVE-1, V_ACTIVE-1):
  - frame_done pulses the next cycle and frame_count increments (0xFFFF -> 0).
  - tvalid drops if the next state is GAP or IDLE.
  - Next state is GAP if GAP_CYCLES > 0. Otherwise it is STREAM if enable=1 (mode relatched, no bubble, tuser on next beat), else IDLE.
- GAP: counts exactly GAP_CYCLES cycles with tvalid=0, then goes to STREAM if enable=1 (relatch), else IDLE.
- enable deasserted mid-frame: the frame completes; enable is only sampled at frame boundaries.
- mode or solid_rgb changes mid-frame: ignored until the next latch.
- Patterns (F = all-ones component):
  - mode 0: solid_rgb.
  - mode 1: 8 vertical bars, in order white, yellow, cyan, green, magenta, red, blue, black. Bar k covers x in [k*H_ACTIVE/8, (k+1)*H_ACTIVE/8), with boundaries as elaboration-time integer constants (no runtime divider). The bar index is a counter advanced at boundaries and reset at line start.
  - mode 2: white if x[CHECK_LOG2] ^ y[CHECK_LOG2], else black.
  - mode 3: R = G = B = x mod 2^BPC.
- busy = 1 in STREAM or GAP.
- Reset mid-frame: immediate return to reset values. No partial-frame completion and no frame_done.

Test Plan:
1. Hold aresetn low with enable=1 -> all outputs 0, frame_count=0. Release: tvalid=1 on the second edge after release, tdata per mode, tuser=1.
2. H_ACTIVE=16, V_ACTIVE=4, mode 0, solid_rgb=0x123456, tready=1 -> exactly 64 beats all 0x123456, tuser only on beat 0, tlast on beats 15/31/47/63, frame_done once, frame_count=1.
3. H_ACTIVE=16, mode 1 -> x0-1 0xFFFFFF, x2-3 yellow (R=FF,G=FF,B=00 -> 0xFF00FF), ..., x14-15 0x000000, repeated each line.
4. Random tready at 50% duty -> tdata/tuser/tlast stable through every stall, beat sequence identical to test 2, no dropped or duplicated pixels.
5. GAP_CYCLES=4 with enable held -> tvalid low exactly 4 cycles between frame-1 tlast transfer and frame-2 tuser beat. GAP_CYCLES=0 -> zero-bubble back-to-back frames.
6. Drop enable and switch mode 0->3 at pixel (5,2) -> frame finishes in mode 0, frame_count increments, then IDLE with busy=0. Re-enable -> ramp frame with pixel x=300 (H_ACTIVE=640) = 0x2C2C2C.
